// File: rtl/aes_dr_pkg.sv
// Shared constants, sequencer state encoding and rail-check helper for the
// dual-rail AES datapath blocks.
package aes_dr_pkg;

  localparam int BYTE   = 8;
  localparam int NBYTES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // A byte pair is well-formed only when every bit differs between the rails.
  function automatic logic rail_ok(input logic [BYTE-1:0] t, input logic [BYTE-1:0] f);
    return &(t ^ f);
  endfunction

endpackage

// File: rtl/dr_byte_mux.sv
// Registered 16:1 dual-rail byte selector; drives the precharge value 0/0
// whenever the requested cycle is not an evaluate cycle.
module dr_byte_mux
  import aes_dr_pkg::*;
(
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NBYTES*BYTE-1:0]   data_t,
  input  logic [NBYTES*BYTE-1:0]   data_f,
  input  logic [$clog2(NBYTES)-1:0] sel,
  input  logic                     eval,
  output logic [BYTE-1:0]          out_t,
  output logic [BYTE-1:0]          out_f
);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      out_t <= '0;
      out_f <= '0;
    end else if (eval) begin
      out_t <= data_t[sel*BYTE +: BYTE];
      out_f <= data_f[sel*BYTE +: BYTE];
    end else begin
      out_t <= '0;
      out_f <= '0;
    end
  end

endmodule

// File: rtl/sbox_sequencer.sv
// Time-shares one precharge-pipelined dual-rail Sbox8b across the 16 state
// bytes for a full SubBytes pass, checking rail complementarity on the way.
module sbox_sequencer
  import aes_dr_pkg::*;
#(
  parameter int SBOX_LAT = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [NBYTES*BYTE-1:0] state_in_T,
  input  logic [NBYTES*BYTE-1:0] state_in_F,
  output logic [BYTE-1:0]        Sbox_In_T,
  output logic [BYTE-1:0]        Sbox_In_F,
  output logic                   flipflpoindicator,
  output logic [1:0]             multi_cycle,
  input  logic [BYTE-1:0]        Sbox_Out_T,
  input  logic [BYTE-1:0]        Sbox_Out_F,
  output logic [NBYTES*BYTE-1:0] state_out_T,
  output logic [NBYTES*BYTE-1:0] state_out_F,
  output logic                   busy,
  output logic                   done,
  output logic                   fault
);

  localparam int CW = $clog2(2*NBYTES + SBOX_LAT);
  localparam logic [CW-1:0] LAST_ISS = CW'(2*NBYTES - 1);
  localparam logic [CW-1:0] LAST_CAP = CW'(2*NBYTES - 2 + SBOX_LAT);
  localparam logic [CW-1:0] LAT_C    = CW'(SBOX_LAT);

  seq_state_t                st;
  logic [CW-1:0]             cyc, nk;
  logic [3:0]                cap_idx;
  logic [NBYTES*BYTE-1:0]    lat_t, lat_f, mux_t, mux_f;
  logic [3:0]                mux_sel;
  logic                      accept, mux_eval, in_rails_ok, cap_now;

  // The mux output is registered, so it is fed next-cycle selects; on the
  // accept edge the incoming state bypasses the latch so byte 0 is on the
  // wire in the very first ISSUE cycle.
  always_comb begin
    accept      = ((st == IDLE) || (st == DONE)) && start;
    nk          = cyc + CW'(1);
    mux_t       = accept ? state_in_T : lat_t;
    mux_f       = accept ? state_in_F : lat_f;
    mux_sel     = accept ? 4'd0 : nk[4:1];
    mux_eval    = accept || ((st == ISSUE) && (cyc != LAST_ISS) && !nk[0]);
    cap_now     = ((st == ISSUE) || (st == DRAIN)) && (cyc >= LAT_C) && !cyc[0];
    in_rails_ok = 1'b1;
    for (int b = 0; b < NBYTES; b++) begin
      in_rails_ok = in_rails_ok & rail_ok(state_in_T[b*BYTE +: BYTE], state_in_F[b*BYTE +: BYTE]);
    end
  end

  dr_byte_mux u_mux (
    .Clk    (Clk),
    .Reset  (Reset),
    .data_t (mux_t),
    .data_f (mux_f),
    .sel    (mux_sel),
    .eval   (mux_eval),
    .out_t  (Sbox_In_T),
    .out_f  (Sbox_In_F)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      st                <= IDLE;
      cyc               <= '0;
      cap_idx           <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      fault             <= 1'b0;
      flipflpoindicator <= 1'b0;
      multi_cycle       <= 2'b00;
      state_out_T       <= '0;
      state_out_F       <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE, DONE: begin
          if (accept) begin
            st                <= ISSUE;
            lat_t             <= state_in_T;
            lat_f             <= state_in_F;
            fault             <= !in_rails_ok;
            cyc               <= '0;
            cap_idx           <= '0;
            busy              <= 1'b1;
            flipflpoindicator <= 1'b1;
            multi_cycle       <= 2'b01;
          end else begin
            st                <= IDLE;
            busy              <= 1'b0;
            flipflpoindicator <= 1'b0;
            multi_cycle       <= 2'b00;
          end
        end
        default: begin
          // multi_cycle carries {issue index parity, evaluate phase}.
          cyc               <= nk;
          flipflpoindicator <= !nk[0];
          multi_cycle       <= {nk[1], !nk[0]};
          if (cap_now) begin
            state_out_T[cap_idx*BYTE +: BYTE] <= Sbox_Out_T;
            state_out_F[cap_idx*BYTE +: BYTE] <= Sbox_Out_F;
            cap_idx <= cap_idx + 4'd1;
            if (!rail_ok(Sbox_Out_T, Sbox_Out_F)) fault <= 1'b1;
          end
          if ((st == ISSUE) && (cyc == LAST_ISS)) st <= DRAIN;
          if ((st == DRAIN) && (cyc == LAST_CAP)) begin
            st                <= DONE;
            busy              <= 1'b0;
            done              <= 1'b1;
            flipflpoindicator <= 1'b0;
            multi_cycle       <= 2'b00;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_sequencer.sv
// Bench for sbox_sequencer: a latency-accurate dual-rail Sbox8b model driven
// by the DUT, with expected results from a GF(2^8) AES S-box reference.
`timescale 1ns/1ps
module tb_sbox_sequencer;

  localparam int LAT  = 4;
  localparam int LAST = 31 + LAT;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         start = 1'b0;
  logic [127:0] state_in_T = '0;
  logic [127:0] state_in_F = '1;
  logic [7:0]   Sbox_In_T, Sbox_In_F, Sbox_Out_T, Sbox_Out_F;
  logic         flipflpoindicator, busy, done, fault;
  logic [1:0]   multi_cycle;
  logic [127:0] state_out_T, state_out_F;

  int checks = 0;
  int errors = 0;
  int inj_idx = -1;
  int eval_cnt = 0;

  logic [7:0] pipe_t [LAT] = '{default: 8'h00};
  logic [7:0] pipe_f [LAT] = '{default: 8'h00};
  logic [7:0] env_v, env_t, env_f;

  always #5 Clk = ~Clk;

  sbox_sequencer #(.SBOX_LAT(LAT)) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .start             (start),
    .state_in_T        (state_in_T),
    .state_in_F        (state_in_F),
    .Sbox_In_T         (Sbox_In_T),
    .Sbox_In_F         (Sbox_In_F),
    .flipflpoindicator (flipflpoindicator),
    .multi_cycle       (multi_cycle),
    .Sbox_Out_T        (Sbox_Out_T),
    .Sbox_Out_F        (Sbox_Out_F),
    .state_out_T       (state_out_T),
    .state_out_F       (state_out_F),
    .busy              (busy),
    .done              (done),
    .fault             (fault)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    if (a != 8'h00)
      for (int c = 1; c < 256; c++)
        if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  // Sbox8b model: a value presented on an evaluate cycle c is seen on
  // Sbox_Out during cycle c+LAT; every other slot carries the 0/0 spacer.
  assign Sbox_Out_T = pipe_t[LAT-1];
  assign Sbox_Out_F = pipe_f[LAT-1];

  always @(posedge Clk) begin
    env_t = 8'h00;
    env_f = 8'h00;
    if (!busy) begin
      eval_cnt = 0;
    end else if (flipflpoindicator) begin
      env_v = sbox(Sbox_In_T);
      env_t = env_v;
      env_f = (eval_cnt == inj_idx) ? env_v : ~env_v;
      eval_cnt++;
    end
    pipe_t[0] <= env_t;
    pipe_f[0] <= env_f;
    for (int k = 1; k < LAT; k++) begin
      pipe_t[k] <= pipe_t[k-1];
      pipe_f[k] <= pipe_f[k-1];
    end
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_pass(input logic [127:0] t, input logic [127:0] f, input int inj,
                          input bit in_bad, input string nm);
    logic [127:0] et, ef;
    logic [7:0]   s, xi_t, xi_f;
    bit           x_flip, x_fault;
    for (int i = 0; i < 16; i++) begin
      s = sbox(t[i*8 +: 8]);
      et[i*8 +: 8] = s;
      ef[i*8 +: 8] = (i == inj) ? s : ~s;
    end
    inj_idx = inj;
    @(negedge Clk);
    start = 1'b1; state_in_T = t; state_in_F = f;
    @(negedge Clk);
    start = 1'b0;
    for (int k = 0; k <= LAST; k++) begin
      x_flip  = (k <= LAST - 1) && (k % 2 == 0);
      x_fault = in_bad || (inj >= 0 && k >= 2*inj + LAT + 1);
      xi_t = (k < 32 && k % 2 == 0) ? t[(k/2)*8 +: 8] : 8'h00;
      xi_f = (k < 32 && k % 2 == 0) ? f[(k/2)*8 +: 8] : 8'h00;
      checks += 6;
      if (busy !== (k < LAST)) begin errors++; $display("FAIL %s busy k=%0d got %b", nm, k, busy); end
      if (done !== (k == LAST)) begin errors++; $display("FAIL %s done k=%0d got %b", nm, k, done); end
      if (flipflpoindicator !== x_flip) begin errors++; $display("FAIL %s flip k=%0d got %b exp %b", nm, k, flipflpoindicator, x_flip); end
      if (Sbox_In_T !== xi_t) begin errors++; $display("FAIL %s sbox_in_t k=%0d got %h exp %h", nm, k, Sbox_In_T, xi_t); end
      if (Sbox_In_F !== xi_f) begin errors++; $display("FAIL %s sbox_in_f k=%0d got %h exp %h", nm, k, Sbox_In_F, xi_f); end
      if (fault !== x_fault) begin errors++; $display("FAIL %s fault k=%0d got %b exp %b", nm, k, fault, x_fault); end
      if (k < 32) begin
        checks++;
        if (multi_cycle !== {1'((k/2) % 2), 1'(k % 2 == 0)}) begin
          errors++; $display("FAIL %s multi_cycle k=%0d got %b", nm, k, multi_cycle);
        end
      end
      if (k == LAST) begin
        checks += 2;
        if (state_out_T !== et) begin errors++; $display("FAIL %s state_out_T got %h exp %h", nm, state_out_T, et); end
        if (state_out_F !== ef) begin errors++; $display("FAIL %s state_out_F got %h exp %h", nm, state_out_F, ef); end
      end
      @(negedge Clk);
    end
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s idle_busy got %b exp 0", nm, busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL %s idle_done got %b exp 0", nm, done); end
    inj_idx = -1;
  endtask

  task automatic check_all_zero(input string nm);
    checks++;
    if ({Sbox_In_T, Sbox_In_F, flipflpoindicator, multi_cycle, state_out_T, state_out_F,
         busy, done, fault} !== '0) begin
      errors++;
      $display("FAIL %s outputs_zero got busy=%b done=%b fault=%b flip=%b mc=%b in=%h/%h outT=%h",
               nm, busy, done, fault, flipflpoindicator, multi_cycle, Sbox_In_T, Sbox_In_F, state_out_T);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b1;
    @(negedge Clk);
    check_all_zero("after_reset");
  endtask

  task automatic test_zero_state();
    run_pass('0, '1, -1, 1'b0, "zero_state");
    checks += 2;
    if (state_out_T !== {16{8'h63}}) begin errors++; $display("FAIL zero_const_T got %h", state_out_T); end
    if (state_out_F !== {16{8'h9C}}) begin errors++; $display("FAIL zero_const_F got %h", state_out_F); end
  endtask

  task automatic test_directed_bytes();
    logic [127:0] t;
    t = {8'h00, {14{8'h01}}, 8'h53};
    run_pass(t, ~t, -1, 1'b0, "directed");
    checks++;
    if (state_out_T !== {8'h63, {14{8'h7C}}, 8'hED}) begin
      errors++; $display("FAIL directed_const got %h", state_out_T);
    end
  endtask

  task automatic test_random();
    logic [127:0] t;
    for (int r = 0; r < 3; r++) begin
      t = rand128();
      run_pass(t, ~t, -1, 1'b0, "random");
    end
  endtask

  task automatic test_out_fault();
    logic [127:0] t;
    t = rand128();
    run_pass(t, ~t, 5, 1'b0, "out_fault");
    t = rand128();
    run_pass(t, ~t, -1, 1'b0, "out_fault_clear");
  endtask

  task automatic test_in_fault();
    logic [127:0] t, f;
    t = rand128();
    f = ~t;
    t[24] = 1'b1;
    f[24] = 1'b1;
    run_pass(t, f, -1, 1'b1, "in_fault");
  endtask

  task automatic test_mid_reset();
    logic [127:0] t;
    t = rand128();
    @(negedge Clk);
    start = 1'b1; state_in_T = t; state_in_F = ~t;
    @(negedge Clk);
    start = 1'b0;
    repeat (10) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check_all_zero("mid_reset");
    Reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_nodone k=%0d got %b exp 0", k, done); end
    end
    t = rand128();
    run_pass(t, ~t, -1, 1'b0, "after_mid_reset");
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b, ea, eb;
    a = rand128();
    b = rand128();
    for (int i = 0; i < 16; i++) begin
      ea[i*8 +: 8] = sbox(a[i*8 +: 8]);
      eb[i*8 +: 8] = sbox(b[i*8 +: 8]);
    end
    @(negedge Clk);
    start = 1'b1; state_in_T = a; state_in_F = ~a;
    @(negedge Clk);
    state_in_T = b; state_in_F = ~b;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k <= LAST; k++) begin
        checks += 2;
        if (done !== (k == LAST)) begin errors++; $display("FAIL b2b_done pass=%0d k=%0d got %b", p, k, done); end
        if (busy !== (k < LAST)) begin errors++; $display("FAIL b2b_busy pass=%0d k=%0d got %b", p, k, busy); end
        if (k == LAST) begin
          checks += 2;
          if (state_out_T !== (p == 0 ? ea : eb)) begin errors++; $display("FAIL b2b_out_T pass=%0d got %h", p, state_out_T); end
          if (fault !== 1'b0) begin errors++; $display("FAIL b2b_fault pass=%0d got %b exp 0", p, fault); end
        end
        @(negedge Clk);
      end
    end
    start = 1'b0;
    repeat (LAST + 2) @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_zero_state();
    test_directed_bytes();
    test_random();
    test_out_fault();
    test_in_fault();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
